joy_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the Genesis multitap/IO block.
- Takes five raw 12-bit host joystick words and applies per-player SOCD cleaning on opposing directions.
- Applies frame-synchronous autofire (turbo) to A/B/C/X/Y/Z.
- Drives the P1..P5 button inputs of the IO/multitap block; the top level breaks the packed outputs into individual button wires.

---
 rtl/joy_pkg.sv | 44 ++++
 rtl/joy_conditioner_if.sv | 34 +++
 rtl/joy_cond_lane.sv | 96 +++++++++
 rtl/joy_conditioner.sv | 72 +++++++
 tb/tb_joy_conditioner.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/joy_pkg.sv
// Shared definitions for the joystick conditioning stage: button bit map,
// SOCD mode codes and turbo helpers.
package joy_pkg;

    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;
    localparam int JB_A     = 4;
    localparam int JB_B     = 5;
    localparam int JB_C     = 6;
    localparam int JB_START = 7;
    localparam int JB_MODE  = 8;
    localparam int JB_X     = 9;
    localparam int JB_Y     = 10;
    localparam int JB_Z     = 11;

    typedef logic [11:0] joy_t;

    typedef enum logic [1:0] {
        SOCD_PASS    = 2'd0,
        SOCD_NEUTRAL = 2'd1,
        SOCD_LAST    = 2'd2
    } socd_mode_e;

    // Turbo half-period in frames: 1, 2, 4 or 8.
    function automatic logic [3:0] turbo_half(input logic [1:0] rate);
        return 4'd1 << rate;
    endfunction

    // Spread the 6-bit per-button turbo enable onto the 12-bit button word.
    function automatic joy_t turbo_bits(input logic [5:0] mask);
        joy_t b;
        b        = '0;
        b[JB_A]  = mask[0];
        b[JB_B]  = mask[1];
        b[JB_C]  = mask[2];
        b[JB_X]  = mask[3];
        b[JB_Y]  = mask[4];
        b[JB_Z]  = mask[5];
        return b;
    endfunction

endpackage

// File: rtl/joy_conditioner_if.sv
// Bundle of joystick inputs, shared controls and conditioned outputs between
// the host side (master) and the conditioner (slave).
interface joy_conditioner_if;
    import joy_pkg::*;

    logic       CE;
    logic       VBLANK;
    joy_t       JOY1;
    joy_t       JOY2;
    joy_t       JOY3;
    joy_t       JOY4;
    joy_t       JOY5;
    logic [5:0] TURBO_MASK;
    logic [1:0] TURBO_RATE;
    logic [1:0] SOCD_MODE;
    joy_t       P1;
    joy_t       P2;
    joy_t       P3;
    joy_t       P4;
    joy_t       P5;

    modport master (
        output CE, VBLANK, JOY1, JOY2, JOY3, JOY4, JOY5,
        output TURBO_MASK, TURBO_RATE, SOCD_MODE,
        input  P1, P2, P3, P4, P5
    );

    modport slave (
        input  CE, VBLANK, JOY1, JOY2, JOY3, JOY4, JOY5,
        input  TURBO_MASK, TURBO_RATE, SOCD_MODE,
        output P1, P2, P3, P4, P5
    );

endinterface

// File: rtl/joy_cond_lane.sv
// One player lane: SOCD cleaning on both direction axes, then frame-based
// autofire on the turbo-capable face buttons, then the output register.
module joy_cond_lane
    import joy_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce_i,
    input  logic       tick_i,
    input  joy_t       joy_i,
    input  logic [5:0] turbo_mask_i,
    input  logic [1:0] turbo_rate_i,
    input  logic [1:0] socd_mode_i,
    output joy_t       p_o
);

    logic [3:0]       dir_q, dir_d;
    // Per axis: 0 = RIGHT/DOWN pressed most recently, 1 = LEFT/UP.
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    joy_t             p_q, p_d;

    joy_t             clean;
    joy_t             tmask;
    logic             hold;
    logic [CNT_W:0]   half_m1;

    assign tmask   = turbo_bits(turbo_mask_i);
    assign hold    = |(joy_i & tmask);
    assign half_m1 = (CNT_W+1)'(turbo_half(turbo_rate_i)) - (CNT_W+1)'(1);

    always_comb begin
        dir_d  = joy_i[JB_UP:JB_RIGHT];
        last_d = last_q;
        clean  = joy_i;
        for (int a = 0; a < 2; a++) begin
            case ({joy_i[2*a+1] & ~dir_q[2*a+1], joy_i[2*a] & ~dir_q[2*a]})
                2'b10:        last_d[a] = 1'b1;
                2'b01, 2'b11: last_d[a] = 1'b0;
                default: ;
            endcase
            if (joy_i[2*a] && joy_i[2*a+1]) begin
                case (socd_mode_i)
                    SOCD_PASS: ;
                    SOCD_LAST: begin
                        if (last_d[a]) clean[2*a]   = 1'b0;
                        else           clean[2*a+1] = 1'b0;
                    end
                    default:   clean[2*a +: 2] = 2'b00;
                endcase
            end
        end
    end

    // Terminal test uses >= so a rate drop below the current count ends the
    // half-period on the next tick instead of wrapping the counter.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!hold) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (tick_i) begin
            if ({1'b0, cnt_q} >= half_m1) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign p_d = (clean & ~tmask) | (clean & tmask & {12{phase_q}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            p_q     <= '0;
        end else if (ce_i) begin
            dir_q   <= dir_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            p_q     <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/joy_conditioner.sv
// Five-player input conditioner feeding the multitap/IO block: reset
// synchroniser, shared VBLANK frame-tick detector and one lane per player.
module joy_conditioner
    import joy_pkg::*;
#(
    parameter int NPLAYERS = 5,
    parameter int CNT_W    = 3
) (
    input  logic CLK,
    input  logic RESET_N,
    joy_conditioner_if.slave bus
);

    logic rst_meta_q;
    logic rst_sync_q;
    logic vbl_q;
    logic tick;
    joy_t joy_arr [NPLAYERS];
    joy_t p_arr   [NPLAYERS];

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    always_ff @(posedge CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            vbl_q <= 1'b0;
        end else if (bus.CE) begin
            vbl_q <= bus.VBLANK;
        end
    end

    assign tick = bus.CE & bus.VBLANK & ~vbl_q;

    assign joy_arr[0] = bus.JOY1;
    assign joy_arr[1] = bus.JOY2;
    assign joy_arr[2] = bus.JOY3;
    assign joy_arr[3] = bus.JOY4;
    assign joy_arr[4] = bus.JOY5;

    generate
        for (genvar gi = 0; gi < NPLAYERS; gi++) begin : g_lane
            joy_cond_lane #(
                .CNT_W (CNT_W)
            ) u_lane (
                .clk          (CLK),
                .rst_n        (rst_sync_q),
                .ce_i         (bus.CE),
                .tick_i       (tick),
                .joy_i        (joy_arr[gi]),
                .turbo_mask_i (bus.TURBO_MASK),
                .turbo_rate_i (bus.TURBO_RATE),
                .socd_mode_i  (bus.SOCD_MODE),
                .p_o          (p_arr[gi])
            );
        end
    endgenerate

    assign bus.P1 = p_arr[0];
    assign bus.P2 = p_arr[1];
    assign bus.P3 = p_arr[2];
    assign bus.P4 = p_arr[3];
    assign bus.P5 = p_arr[4];

endmodule

// File: tb/tb_joy_conditioner.sv
// Bench for joy_conditioner: directed scenarios with literal expectations plus
// randomized traffic checked against a frame/press-level reference model.
module tb_joy_conditioner;
    import joy_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N;

    joy_conditioner_if bus();

    joy_conditioner #(
        .NPLAYERS (5),
        .CNT_W    (3)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int   tpos [6] = '{4, 5, 6, 9, 10, 11};
    bit   m_vbl;
    logic [3:0] m_prev [5];
    bit   m_last [5][2];
    int   m_frames [5];
    bit   m_phase [5];
    joy_t exp_p [5];

    function automatic joy_t get_joy(input int p);
        case (p)
            0: return bus.JOY1;
            1: return bus.JOY2;
            2: return bus.JOY3;
            3: return bus.JOY4;
            default: return bus.JOY5;
        endcase
    endfunction

    function automatic joy_t get_p(input int p);
        case (p)
            0: return bus.P1;
            1: return bus.P2;
            2: return bus.P3;
            3: return bus.P4;
            default: return bus.P5;
        endcase
    endfunction

    task automatic set_joy(input int p, input joy_t v);
        case (p)
            0: bus.JOY1 = v;
            1: bus.JOY2 = v;
            2: bus.JOY3 = v;
            3: bus.JOY4 = v;
            default: bus.JOY5 = v;
        endcase
    endtask

    task automatic model_reset();
        m_vbl = 1'b0;
        for (int p = 0; p < 5; p++) begin
            m_prev[p]    = 4'h0;
            m_last[p][0] = 1'b0;
            m_last[p][1] = 1'b0;
            m_frames[p]  = 0;
            m_phase[p]   = 1'b1;
            exp_p[p]     = '0;
        end
    endtask

    task automatic model_step();
        bit   tick;
        joy_t j, o, tm;
        bit   held;
        int   half;
        tick  = bus.VBLANK && !m_vbl;
        m_vbl = bus.VBLANK;
        half  = 1 << bus.TURBO_RATE;
        tm    = '0;
        for (int k = 0; k < 6; k++)
            if (bus.TURBO_MASK[k]) tm[tpos[k]] = 1'b1;
        for (int p = 0; p < 5; p++) begin
            j = get_joy(p);
            o = j;
            for (int a = 0; a < 2; a++) begin
                if (j[2*a] && !m_prev[p][2*a])          m_last[p][a] = 1'b0;
                else if (j[2*a+1] && !m_prev[p][2*a+1]) m_last[p][a] = 1'b1;
                if (j[2*a] && j[2*a+1]) begin
                    if (bus.SOCD_MODE == 2'd2) begin
                        if (m_last[p][a]) o[2*a] = 1'b0;
                        else              o[2*a+1] = 1'b0;
                    end else if (bus.SOCD_MODE != 2'd0) begin
                        o[2*a]   = 1'b0;
                        o[2*a+1] = 1'b0;
                    end
                end
            end
            m_prev[p] = j[3:0];
            if (!m_phase[p]) o = o & ~tm;
            held = (j & tm) != 12'h000;
            if (!held) begin
                m_frames[p] = 0;
                m_phase[p]  = 1'b1;
            end else if (tick) begin
                if (m_frames[p] + 1 >= half) begin
                    m_frames[p] = 0;
                    m_phase[p]  = !m_phase[p];
                end else begin
                    m_frames[p] = m_frames[p] + 1;
                end
            end
            exp_p[p] = o;
        end
    endtask

    // One clock: the model follows the same sampled inputs; outputs are
    // observed 1 time unit after the edge.
    task automatic cycle();
        @(posedge CLK);
        if (RESET_N && bus.CE) model_step();
        #1;
    endtask

    task automatic tick_frame();
        bus.VBLANK = 1'b1;
        cycle();
        bus.VBLANK = 1'b0;
        cycle();
    endtask

    task automatic release_reset();
        RESET_N = 1'b1;
        bus.CE  = 1'b0;
        repeat (3) cycle();
        bus.CE  = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N        = 1'b0;
        bus.CE         = 1'b0;
        bus.VBLANK     = 1'b0;
        bus.SOCD_MODE  = 2'd1;
        bus.TURBO_MASK = 6'h00;
        bus.TURBO_RATE = 2'd0;
        for (int p = 0; p < 5; p++) set_joy(p, 12'h000);
        bus.JOY1 = 12'hFFF;
        model_reset();
        #1;
        checks++;
        if (bus.P1 !== 12'h000) begin
            errors++;
            $display("FAIL reset_p1 got=%h exp=%h", bus.P1, 12'h000);
        end
        repeat (2) cycle();
        release_reset();
        cycle();
        checks++;
        if (bus.P1 !== 12'hFF0) begin
            errors++;
            $display("FAIL reset_release_p1 got=%h exp=%h", bus.P1, 12'hFF0);
        end
        $display("reset: P1=%h", bus.P1);
    endtask

    task automatic test_socd_neutral();
        bus.CE        = 1'b1;
        bus.SOCD_MODE = 2'd1;
        bus.JOY1      = 12'h000;
        bus.JOY2      = 12'h003;
        cycle();
        checks++;
        if (bus.P2[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL socd_neutral_both got=%b exp=%b", bus.P2[1:0], 2'b00);
        end
        bus.JOY2 = 12'h001;
        cycle();
        checks++;
        if (bus.P2[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL socd_neutral_right got=%b exp=%b", bus.P2[1:0], 2'b01);
        end
        bus.SOCD_MODE = 2'd3;
        bus.JOY2      = 12'h00C;
        cycle();
        checks++;
        if (bus.P2[3:0] !== 4'b0000) begin
            errors++;
            $display("FAIL socd_reserved_ud got=%b exp=%b", bus.P2[3:0], 4'b0000);
        end
        $display("socd_neutral: P2=%h", bus.P2);
    endtask

    task automatic test_socd_last();
        joy_t stim [7] = '{12'h001, 12'h003, 12'h001, 12'h000, 12'h003, 12'h000, 12'h004};
        logic [1:0] want [7] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
        bus.SOCD_MODE = 2'd2;
        bus.JOY3      = 12'h000;
        cycle();
        for (int i = 0; i < 7; i++) begin
            bus.JOY3 = stim[i];
            cycle();
            checks++;
            if (bus.P3[1:0] !== want[i]) begin
                errors++;
                $display("FAIL socd_last_lr step=%0d got=%b exp=%b", i, bus.P3[1:0], want[i]);
            end
        end
        bus.JOY3 = 12'h00C;
        cycle();
        checks++;
        if (bus.P3[3:0] !== 4'b1000) begin
            errors++;
            $display("FAIL socd_last_ud got=%b exp=%b", bus.P3[3:0], 4'b1000);
        end
        bus.SOCD_MODE = 2'd0;
        bus.JOY3      = 12'h00F;
        cycle();
        checks++;
        if (bus.P3[3:0] !== 4'b1111) begin
            errors++;
            $display("FAIL socd_pass got=%b exp=%b", bus.P3[3:0], 4'b1111);
        end
        $display("socd_last: P3=%h", bus.P3);
    endtask

    task automatic test_turbo();
        bit seq [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.SOCD_MODE  = 2'd0;
        bus.TURBO_MASK = 6'h01;
        bus.TURBO_RATE = 2'd1;
        bus.VBLANK     = 1'b0;
        for (int p = 0; p < 5; p++) set_joy(p, 12'h000);
        cycle();
        bus.JOY1 = 12'h010;
        cycle();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick_frame();
            checks++;
            if (bus.P1[4] !== seq[k]) begin
                errors++;
                $display("FAIL turbo_seq frame=%0d got=%b exp=%b", k, bus.P1[4], seq[k]);
            end
        end
        bus.JOY1 = 12'h000;
        cycle();
        checks++;
        if (bus.P1[4] !== 1'b0) begin
            errors++;
            $display("FAIL turbo_release got=%b exp=%b", bus.P1[4], 1'b0);
        end
        bus.JOY1 = 12'h010;
        cycle();
        checks++;
        if (bus.P1[4] !== 1'b1) begin
            errors++;
            $display("FAIL turbo_repress got=%b exp=%b", bus.P1[4], 1'b1);
        end
        $display("turbo: P1=%h", bus.P1);
    endtask

    task automatic test_rate_change();
        bus.JOY1       = 12'h000;
        bus.TURBO_MASK = 6'h01;
        bus.TURBO_RATE = 2'd3;
        cycle();
        bus.JOY1 = 12'h010;
        cycle();
        repeat (5) tick_frame();
        checks++;
        if (bus.P1[4] !== 1'b1) begin
            errors++;
            $display("FAIL rate_before got=%b exp=%b", bus.P1[4], 1'b1);
        end
        bus.TURBO_RATE = 2'd0;
        tick_frame();
        checks++;
        if (bus.P1[4] !== 1'b0) begin
            errors++;
            $display("FAIL rate_drop got=%b exp=%b", bus.P1[4], 1'b0);
        end
        tick_frame();
        checks++;
        if (bus.P1[4] !== 1'b1) begin
            errors++;
            $display("FAIL rate_after got=%b exp=%b", bus.P1[4], 1'b1);
        end
        $display("rate_change: P1=%h", bus.P1);
    endtask

    task automatic test_ce_gating();
        joy_t snap [5];
        bus.CE = 1'b1;
        for (int p = 0; p < 5; p++) set_joy(p, joy_t'($urandom));
        cycle();
        for (int p = 0; p < 5; p++) snap[p] = exp_p[p];
        bus.CE = 1'b0;
        for (int c = 0; c < 10; c++) begin
            for (int p = 0; p < 5; p++) set_joy(p, joy_t'($urandom));
            bus.VBLANK = c[0];
            cycle();
            for (int p = 0; p < 5; p++) begin
                checks++;
                if (get_p(p) !== snap[p]) begin
                    errors++;
                    $display("FAIL ce_hold cyc=%0d P%0d got=%h exp=%h", c, p + 1, get_p(p), snap[p]);
                end
            end
        end
        bus.VBLANK = 1'b0;
        bus.CE     = 1'b1;
        $display("ce_gating: P1=%h", bus.P1);
    endtask

    task automatic test_mid_reset();
        bus.CE         = 1'b1;
        bus.VBLANK     = 1'b0;
        bus.SOCD_MODE  = 2'd0;
        bus.TURBO_MASK = 6'h01;
        bus.TURBO_RATE = 2'd0;
        for (int p = 0; p < 5; p++) set_joy(p, 12'h000);
        cycle();
        bus.JOY1 = 12'h0B0;
        cycle();
        tick_frame();
        checks++;
        if (bus.P1 !== 12'h0A0) begin
            errors++;
            $display("FAIL midreset_turbo_off got=%h exp=%h", bus.P1, 12'h0A0);
        end
        RESET_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.P1 !== 12'h000) begin
            errors++;
            $display("FAIL midreset_async got=%h exp=%h", bus.P1, 12'h000);
        end
        release_reset();
        cycle();
        checks++;
        if (bus.P1 !== 12'h0B0) begin
            errors++;
            $display("FAIL midreset_release got=%h exp=%h", bus.P1, 12'h0B0);
        end
        $display("mid_reset: P1=%h", bus.P1);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) begin
                bus.TURBO_MASK = 6'($urandom);
                bus.TURBO_RATE = 2'($urandom);
                bus.SOCD_MODE  = 2'($urandom);
            end
            for (int p = 0; p < 5; p++)
                if ($urandom_range(0, 3) == 0) set_joy(p, joy_t'($urandom));
            bus.CE = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) == 0) bus.VBLANK = ~bus.VBLANK;
            cycle();
            for (int p = 0; p < 5; p++) begin
                checks++;
                if (get_p(p) !== exp_p[p]) begin
                    errors++;
                    bad++;
                    $display("FAIL random cyc=%0d P%0d got=%h exp=%h", c, p + 1, get_p(p), exp_p[p]);
                end
            end
        end
        $display("random: 600 cycles, %0d mismatching lanes", bad);
    endtask

    initial begin
        test_reset();
        test_socd_neutral();
        test_socd_last();
        test_turbo();
        test_rate_change();
        test_ce_gating();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
